// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the register interface.
// Optional fill-level interrupt is built only when UART_RX_FIFO_THRESH_EN is defined.
module uart_rx_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic              clr_ovf_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [ADDR_W:0]   count_o,
   output logic              overflow_o,
   input  logic [ADDR_W:0]   thresh_i,
   output logic              level_irq_o
);

   localparam logic [ADDR_W:0] DepthCount = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              overflow_q, overflow_d;

   logic empty, full;
   logic rd_acc, wr_acc, wr_drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == DepthCount);

   // A read on a full FIFO frees the slot the same-cycle write needs.
   assign rd_acc  = rd_en_i && !empty;
   assign wr_acc  = wr_valid_i && (!full || rd_acc);
   assign wr_drop = wr_valid_i && full && !rd_acc;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      overflow_d = overflow_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end

      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
         rd_data_d  = mem_q[rd_ptr_q];
         rd_valid_d = 1'b1;
      end

      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase

      if (wr_drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf_i) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; it is only ever read behind a valid count.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

`ifdef UART_RX_FIFO_THRESH_EN
   logic level_irq_q, level_irq_d;

   always_comb begin
      level_irq_d = (count_d >= thresh_i);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level_irq_q <= 1'b0;
      end else begin
         level_irq_q <= level_irq_d;
      end
   end

   assign level_irq_o = level_irq_q;
`else
   logic unused_thresh;
   assign unused_thresh = ^thresh_i;
   assign level_irq_o   = 1'b0;
`endif

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign empty_o    = empty;
   assign full_o     = full;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Threshold checks adapt to whether UART_RX_FIFO_THRESH_EN is defined.
module tb_uart_rx_fifo;

   logic       clk;
   logic       reset;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       rd_en;
   logic       clr_ovf;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic [4:0] thresh;
   logic       level_irq;

   int errors = 0;
   int checks = 0;

   uart_rx_fifo #(
      .DATA_W(8),
      .DEPTH (16),
      .ADDR_W(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_valid_i (wr_valid),
      .wr_data_i  (wr_data),
      .rd_en_i    (rd_en),
      .clr_ovf_i  (clr_ovf),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid),
      .empty_o    (empty),
      .full_o     (full),
      .count_o    (count),
      .overflow_o (overflow),
      .thresh_i   (thresh),
      .level_irq_o(level_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1ns after an edge; outputs are sampled 1ns after the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check({tag, "_valid"}, rd_valid, 1);
      check({tag, "_data"}, rd_data, exp);
   endtask

   initial begin
      reset    = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      rd_en    = 1'b0;
      clr_ovf  = 1'b0;
      thresh   = 5'd4;
      #1;
      tick();
      tick();
      reset = 1'b0;

      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_overflow", overflow, 0);
      check("rst_level_irq", level_irq, 0);

      // 1: single byte through
      push(8'hA5);
      check("t1_empty", empty, 0);
      check("t1_count", count, 1);
      pop_check("t1_rd", 8'hA5);
      check("t1_empty_after", empty, 1);
      tick();
      check("t1_valid_pulse", rd_valid, 0);
      check("t1_data_hold", rd_data, 8'hA5);

      // 2: fill, overflow, drain in order, clear overflow
      for (int i = 0; i < 16; i++) push(8'(i));
      check("t2_full", full, 1);
      check("t2_count16", count, 16);
      check("t2_no_ovf", overflow, 0);
      push(8'h55);
      check("t2_overflow", overflow, 1);
      check("t2_count_hold", count, 16);
      for (int i = 0; i < 16; i++) pop_check("t2_drain", 8'(i));
      check("t2_empty", empty, 1);
      check("t2_ovf_sticky", overflow, 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("t2_clr_ovf", overflow, 0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t2_empty_rd_valid", rd_valid, 0);
      check("t2_empty_rd_hold", rd_data, 8'h0F);
      check("t2_empty_count", count, 0);

      // overflow set wins over clr_ovf in the same cycle
      for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      clr_ovf  = 1'b1;
      tick();
      wr_valid = 1'b0;
      clr_ovf  = 1'b0;
      check("t2_set_beats_clr", overflow, 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("t2_clr_again", overflow, 0);

      // 3: full + simultaneous read and write
      wr_valid = 1'b1;
      wr_data  = 8'h77;
      rd_en    = 1'b1;
      tick();
      wr_valid = 1'b0;
      rd_en    = 1'b0;
      check("t3_count", count, 16);
      check("t3_overflow", overflow, 0);
      check("t3_rd_data", rd_data, 8'h10);
      check("t3_rd_valid", rd_valid, 1);
      for (int i = 1; i < 16; i++) pop_check("t3_drain", 8'h10 + 8'(i));
      pop_check("t3_last", 8'h77);
      check("t3_empty", empty, 1);

      // 4: empty + simultaneous read and write
      wr_valid = 1'b1;
      wr_data  = 8'h3C;
      rd_en    = 1'b1;
      tick();
      wr_valid = 1'b0;
      rd_en    = 1'b0;
      check("t4_rd_valid", rd_valid, 0);
      check("t4_count", count, 1);
      pop_check("t4_rd", 8'h3C);

      // 5: pointer wrap, then reset with contents stored
      for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
      for (int i = 0; i < 10; i++) pop_check("t5_a", 8'h40 + 8'(i));
      for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
      check("t5_count10", count, 10);
      for (int i = 0; i < 10; i++) pop_check("t5_b", 8'hC0 + 8'(i));
      for (int i = 0; i < 5; i++) push(8'h90 + 8'(i));
      check("t5_count5", count, 5);
      reset = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'hAA;
      tick();
      reset    = 1'b0;
      wr_valid = 1'b0;
      check("t5_rst_count", count, 0);
      check("t5_rst_empty", empty, 1);
      check("t5_rst_rd_data", rd_data, 0);
      push(8'h99);
      check("t5_post_count", count, 1);
      pop_check("t5_post_rd", 8'h99);

      // 6: level interrupt, thresh = 4 (count is 0 here)
      thresh = 5'd4;
      for (int i = 0; i < 3; i++) push(8'h20 + 8'(i));
      check("t6_irq_at3", level_irq, 0);
      push(8'h23);
`ifdef UART_RX_FIFO_THRESH_EN
      check("t6_irq_at4", level_irq, 1);
`else
      check("t6_irq_at4", level_irq, 0);
`endif
      pop_check("t6_rd", 8'h20);
      check("t6_irq_fall", level_irq, 0);
      for (int i = 1; i < 4; i++) pop_check("t6_drain", 8'h20 + 8'(i));

      thresh = 5'd0;
      reset  = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_thr0_rst", level_irq, 0);
      tick();
`ifdef UART_RX_FIFO_THRESH_EN
      check("t6_thr0_irq", level_irq, 1);
`else
      check("t6_thr0_irq", level_irq, 0);
`endif

      thresh = 5'd17;
      for (int i = 0; i < 16; i++) push(8'(i));
      check("t6_thr17_full", full, 1);
      check("t6_thr17_irq", level_irq, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
